reg_writeback_buffer: RTL and testbench
=======================================

// Module: reg_writeback_buffer
// PURPOSE
//   Write-side companion of the 8x16 register bank. Accepts writeback results (dest, data) from
//   the execute stage, buffers them in a small in-order FIFO, and drains one per acknowledged
//   cycle into the bank write port. Offers read-after-write forwarding for the two read selects
//   so decode sees pending values before they land in the bank.
// PARAMETERS
//   DEPTH   4    write-buffer entries; power of two, >= 2
//   DW      16   data width
//   AW      3    register address width (2**AW registers)
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous, active-high reset
//   in_valid   in   1        writeback request present
//   in_ready   out  1        buffer can accept this cycle
//   in_dest    in   AW       destination register
//   in_data    in   DW       value to write
//   wr_en      out  1        bank write request (head entry valid)
//   wr_addr    out  AW       bank write address
//   wr_data    out  DW       bank write data
//   wr_ack     in   1        bank accepted the write this cycle
//   select1    in   AW       read select 1 (same encoding as bank read port)
//   select2    in   AW       read select 2
//   fwd1_hit   out  1        pending write to select1 exists
//   fwd1_data  out  DW       youngest pending value for select1
//   fwd2_hit   out  1        pending write to select2 exists
//   fwd2_data  out  DW       youngest pending value for select2
//   count      out  log2(DEPTH)+1   occupied entries
// BEHAVIOUR
//   - Reset (async, immediate): head/tail pointers and count = 0; pending entries discarded.
//     Outputs during/after reset: in_ready=1, wr_en=0, wr_addr=0, wr_data=0, fwd*_hit=0,
//     fwd*_data=0, count=0. Entry storage itself is not reset.
//   - Push: in_valid && in_ready at posedge -> entry written at tail, tail++ (wraps mod DEPTH).
//   - in_ready = (count != DEPTH); combinational from registered count only. When full, in_ready=0
//     even if a pop occurs the same cycle (no full-buffer pass-through).
//   - Drain: wr_en = (count != 0); wr_addr/wr_data = head entry, 0 when empty.
//     Pop on posedge when wr_en && wr_ack; head++ (wraps). wr_ack while wr_en=0 is ignored.
//     wr_addr/wr_data stay stable while wr_en=1 and wr_ack=0.
//   - Latency: accepted entry appears on wr_en no earlier than the next cycle; no same-cycle
//     bypass from in_* to wr_*. Writes leave in strict arrival order.
//   - Simultaneous push+pop (0<count<DEPTH): count unchanged, both pointers advance.
//     Push into empty + ack: ack ignored (wr_en was 0), count -> 1.
//   - count: +1 on push only, -1 on pop only, unchanged otherwise; never exceeds DEPTH.
//   - Forwarding (combinational on registered entries): fwdN_hit=1 iff any occupied entry has
//     dest==selectN; fwdN_data = data of youngest such entry (closest to tail); 0 when no hit.
//     The in_* word of the current cycle is NOT forwarded. The head entry being acked this
//     cycle still counts as a hit this cycle.
//   - Duplicate dests in buffer are all written to the bank in order; no coalescing.
// TESTING
//   1 Reset: assert rst mid-run with 3 entries pending -> wr_en=0, count=0, in_ready=1 at once.
//   2 Fill: wr_ack=0, push (1,0x1111),(2,0x2222),(3,0x3333),(4,0x4444) -> count=4, in_ready=0,
//     5th push ignored; wr_addr=1, wr_data=0x1111 held stable.
//   3 Drain order: from case 2 hold wr_ack=1 -> addresses 1,2,3,4 on four consecutive cycles,
//     then wr_en=0, count=0.
//   4 Forward youngest: push (5,0xAAAA) then (5,0xBBBB), wr_ack=0, select1=5, select2=6 ->
//     fwd1_hit=1, fwd1_data=0xBBBB, fwd2_hit=0, fwd2_data=0.
//   5 Concurrent push/pop: count=2, wr_ack=1 and push each cycle for 10 cycles -> count stays 2,
//     bank sees writes in push order, pointers wrap without loss.
//   6 Full+ack: count=DEPTH, wr_ack=1, in_valid=1 -> in_ready=0 that cycle, count becomes 3,
//     next cycle in_ready=1 and push accepted.

Source files
------------

// File: rtl/reg_writeback_buffer.sv
// Writeback buffer: in-order FIFO in front of the register bank write port,
// with read-after-write forwarding on two read selects.

// Forwarding lookup for one read select: scans occupied entries from oldest to
// youngest so the last match (closest to tail) wins.
module reg_wb_fwd #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 3,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][AW-1:0] dest_i,
  input  logic [DEPTH-1:0][DW-1:0] data_i,
  input  logic [PW-1:0]            head_i,
  input  logic [PW:0]              count_i,
  input  logic [AW-1:0]            sel_i,
  output logic                     hit_o,
  output logic [DW-1:0]            data_o
);
  logic [PW-1:0] idx;

  // Age-ordered scan; a younger match overrides an older one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if ((k < int'(count_i)) && (dest_i[idx] == sel_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end
endmodule

module reg_writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [AW-1:0]             in_dest,
  input  logic [DW-1:0]             in_data,
  output logic                      wr_en,
  output logic [AW-1:0]             wr_addr,
  output logic [DW-1:0]             wr_data,
  input  logic                      wr_ack,
  input  logic [AW-1:0]             select1,
  input  logic [AW-1:0]             select2,
  output logic                      fwd1_hit,
  output logic [DW-1:0]             fwd1_data,
  output logic                      fwd2_hit,
  output logic [DW-1:0]             fwd2_data,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int PW = $clog2(DEPTH);
  localparam int NSEL = 2;

  logic [DEPTH-1:0][AW-1:0] dest_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [PW:0]              count_q, count_d;
  logic                     push, pop;

  logic [NSEL-1:0][AW-1:0]  sel;
  logic [NSEL-1:0]          hit;
  logic [NSEL-1:0][DW-1:0]  fdata;

  // Ready and drain derive only from registered occupancy; no bypass paths.
  assign in_ready = (count_q != (PW+1)'(DEPTH));
  assign wr_en    = (count_q != '0);
  assign wr_addr  = wr_en ? dest_q[head_q] : '0;
  assign wr_data  = wr_en ? data_q[head_q] : '0;
  assign push     = in_valid && in_ready;
  assign pop      = wr_en && wr_ack;
  assign count    = count_q;

  // Pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Control state; reset discards pending entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[tail_q] <= in_dest;
      data_q[tail_q] <= in_data;
    end
  end

  assign sel[0] = select1;
  assign sel[1] = select2;

  for (genvar s = 0; s < NSEL; s++) begin : g_fwd
    reg_wb_fwd #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .PW(PW)) u_fwd (
      .dest_i  (dest_q),
      .data_i  (data_q),
      .head_i  (head_q),
      .count_i (count_q),
      .sel_i   (sel[s]),
      .hit_o   (hit[s]),
      .data_o  (fdata[s])
    );
  end

  assign fwd1_hit  = hit[0];
  assign fwd1_data = fdata[0];
  assign fwd2_hit  = hit[1];
  assign fwd2_data = fdata[1];
endmodule

// File: tb/tb_reg_writeback_buffer.sv
// Directed bench for reg_writeback_buffer (DEPTH=4, DW=16, AW=3).
module tb_reg_writeback_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_dest;
  logic [15:0] in_data;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic [2:0]  select1, select2;
  logic        fwd1_hit, fwd2_hit;
  logic [15:0] fwd1_data, fwd2_data;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [2:0]  q_dest[$];
  logic [15:0] q_data[$];

  reg_writeback_buffer #(.DEPTH(4), .DW(16), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .select1(select1), .select2(select2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled well clear of the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_dest = '0; in_data = '0;
    wr_ack = 1'b0; select1 = '0; select2 = '0;
    tick(); tick();
    chk("rst_ready", in_ready, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_count", count, 0);
    chk("rst_addr",  wr_addr, 0);
    chk("rst_data",  wr_data, 0);
    chk("rst_fwd1",  fwd1_hit, 0);
    rst = 1'b0;
    tick();

    // Fill with ack held low; the fifth push must be refused.
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_dest = 3'(i); in_data = 16'(i * 16'h1111);
      tick();
    end
    in_dest = 3'd7; in_data = 16'h7777;
    settle();
    chk("full_count", count, 4);
    chk("full_ready", in_ready, 0);
    chk("full_addr",  wr_addr, 1);
    chk("full_data",  wr_data, 16'h1111);
    tick();
    in_valid = 1'b0;
    select1 = 3'd3; select2 = 3'd7;
    settle();
    chk("full_count2", count, 4);
    chk("hold_addr",   wr_addr, 1);
    chk("hold_data",   wr_data, 16'h1111);
    chk("fwd_mid_hit", fwd1_hit, 1);
    chk("fwd_mid_dat", fwd1_data, 16'h3333);
    chk("fwd_rej_hit", fwd2_hit, 0);

    // Drain in arrival order.
    wr_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("drain_en",   wr_en, 1);
      chk("drain_addr", wr_addr, 32'(i));
      chk("drain_data", wr_data, 32'(i * 16'h1111));
      tick();
    end
    chk("empty_en",    wr_en, 0);
    chk("empty_count", count, 0);
    chk("empty_addr",  wr_addr, 0);
    tick();
    chk("ack_empty_count", count, 0);

    // Youngest duplicate wins; current input word is not forwarded.
    wr_ack = 1'b0;
    in_valid = 1'b1; in_dest = 3'd5; in_data = 16'hAAAA; tick();
    in_data = 16'hBBBB; tick();
    in_dest = 3'd6; in_data = 16'hCCCC;
    select1 = 3'd5; select2 = 3'd6;
    settle();
    chk("fwd1_hit",  fwd1_hit, 1);
    chk("fwd1_data", fwd1_data, 16'hBBBB);
    chk("fwd2_hit",  fwd2_hit, 0);
    chk("fwd2_data", fwd2_data, 0);
    in_valid = 1'b0;
    settle();
    chk("dup_count", count, 2);

    // Concurrent push and pop for 10 cycles; pointers wrap.
    q_dest = '{3'd5, 3'd5};
    q_data = '{16'hAAAA, 16'hBBBB};
    wr_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_dest = 3'(i % 8); in_data = 16'(16'h1000 + i);
      settle();
      chk("pp_count", count, 2);
      chk("pp_addr",  wr_addr, q_dest[0]);
      chk("pp_data",  wr_data, q_data[0]);
      void'(q_dest.pop_front()); void'(q_data.pop_front());
      q_dest.push_back(in_dest); q_data.push_back(in_data);
      tick();
    end
    chk("pp_end_count", count, 2);
    chk("pp_end_addr",  wr_addr, 0);
    chk("pp_end_data",  wr_data, 16'h1008);

    // Full plus ack: push refused that cycle, accepted the next.
    wr_ack = 1'b0;
    in_dest = 3'd2; in_data = 16'h2A2A; tick();
    in_dest = 3'd3; in_data = 16'h3B3B; tick();
    wr_ack = 1'b1; in_dest = 3'd6; in_data = 16'h6666;
    select1 = 3'd0; select2 = 3'd6;
    settle();
    chk("fa_count", count, 4);
    chk("fa_ready", in_ready, 0);
    chk("fa_head_hit", fwd1_hit, 1);
    chk("fa_head_dat", fwd1_data, 16'h1008);
    tick();
    chk("fa_count2", count, 3);
    chk("fa_ready2", in_ready, 1);
    chk("fa_addr2",  wr_addr, 1);
    chk("fa_fwd6",   fwd2_hit, 0);
    tick();
    wr_ack = 1'b0; in_valid = 1'b0;
    settle();
    chk("fa_count3", count, 3);
    chk("fa_fwd6b",  fwd2_hit, 1);
    chk("fa_fwd6d",  fwd2_data, 16'h6666);
    chk("fa_addr3",  wr_addr, 2);

    // Asynchronous reset mid-cycle with three entries pending.
    rst = 1'b1;
    settle();
    chk("ar_en",    wr_en, 0);
    chk("ar_count", count, 0);
    chk("ar_ready", in_ready, 1);
    chk("ar_addr",  wr_addr, 0);
    chk("ar_fwd",   fwd2_hit, 0);
    chk("ar_fdat",  fwd2_data, 0);
    rst = 1'b0;
    tick();
    in_valid = 1'b1; in_dest = 3'd7; in_data = 16'h7777;
    tick();
    in_valid = 1'b0;
    settle();
    chk("post_count", count, 1);
    chk("post_addr",  wr_addr, 7);
    chk("post_data",  wr_data, 16'h7777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
